// File: rtl/div_sched.sv
// div_sched: shares one iterative 32-bit divider between NUM_REQ requesters.
// Round-robin arbitration, one-cycle launch pulse, quotient routed back to the
// owning requester, and a watchdog that aborts an operation if the divider
// never answers. All outputs are registered.
// Optional feature macro: DIV_ZERO_BYPASS_EN. When it is defined, a zero
// divisor is answered with an error immediately and the divider is not launched.
module div_sched #(
    parameter int NUM_REQ = 2,
    parameter int MAX_CYC = 64,
    parameter int CNT_W   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [32*NUM_REQ-1:0] req_num,
    input  logic [32*NUM_REQ-1:0] req_den,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    resp_vld,
    output logic [31:0]           resp_q,
    output logic                  resp_err,
    output logic                  div_start,
    output logic [31:0]           div_num,
    output logic [31:0]           div_den,
    input  logic [31:0]           div_q,
    input  logic                  div_vld,
    output logic                  busy
);

    localparam int                 IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_CYC - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [31:0]        ERR_Q    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_zero;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_resp_vld;
    logic [31:0]        r_resp_q;
    logic               r_resp_err;
    logic               r_div_start;
    logic [31:0]        r_div_num;
    logic [31:0]        r_div_den;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_zero_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [NUM_REQ-1:0] w_resp_vld_nxt;
    logic [31:0]        w_resp_q_nxt;
    logic               w_resp_err_nxt;
    logic               w_start_nxt;
    logic [31:0]        w_num_nxt;
    logic [31:0]        w_den_nxt;
    logic               w_busy_nxt;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_rr_inc;
    logic [31:0]        w_num;
    logic [31:0]        w_den;
    logic               w_bypass;

    // Round-robin search: first asserted request at or above the pointer, wrapping.
    always_comb begin
        int sum;
        int idx;
        logic hit;
        w_found = 1'b0;
        w_win   = '0;
        sum     = 0;
        idx     = 0;
        hit     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum     = int'(r_rr) + k;
            idx     = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
            hit     = !w_found && req[IDX_W'(idx)];
            w_win   = hit ? IDX_W'(idx) : w_win;
            w_found = w_found | hit;
        end
    end

    assign w_rr_inc = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : (w_win + IDX_W'(1));
    assign w_num    = req_num[{w_win, 5'd0} +: 32];
    assign w_den    = req_den[{w_win, 5'd0} +: 32];

`ifdef DIV_ZERO_BYPASS_EN
    assign w_bypass = (w_den == 32'd0);
`else
    assign w_bypass = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_owner_nxt    = r_owner;
        w_cnt_nxt      = r_cnt;
        w_zero_nxt     = r_zero;
        w_gnt_nxt      = '0;
        w_resp_vld_nxt = '0;
        w_start_nxt    = 1'b0;
        w_resp_q_nxt   = r_resp_q;
        w_resp_err_nxt = r_resp_err;
        w_num_nxt      = r_div_num;
        w_den_nxt      = r_div_den;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = ONE_HOT0 << w_win;
                    w_start_nxt = !w_bypass;
                    w_num_nxt   = w_num;
                    w_den_nxt   = w_den;
                    w_owner_nxt = w_win;
                    w_rr_nxt    = w_rr_inc;
                    w_cnt_nxt   = '0;
                    w_zero_nxt  = w_bypass;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A bypassed zero divisor spends its single WAIT cycle here so the
                // registered response lands two cycles after the request is sampled.
                if (r_zero) begin
                    w_resp_q_nxt   = ERR_Q;
                    w_resp_err_nxt = 1'b1;
                    w_resp_vld_nxt = ONE_HOT0 << r_owner;
                    w_zero_nxt     = 1'b0;
                    w_state_nxt    = ST_RESP;
                end else if (div_vld && !r_div_start) begin
                    // Valid beats the watchdog when both land on the same edge.
                    w_resp_q_nxt   = div_q;
                    w_resp_err_nxt = 1'b0;
                    w_resp_vld_nxt = ONE_HOT0 << r_owner;
                    w_state_nxt    = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_resp_q_nxt   = ERR_Q;
                    w_resp_err_nxt = 1'b1;
                    w_resp_vld_nxt = ONE_HOT0 << r_owner;
                    w_state_nxt    = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers with synchronous reset; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr        <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_zero      <= 1'b0;
            r_gnt       <= '0;
            r_resp_vld  <= '0;
            r_resp_q    <= 32'd0;
            r_resp_err  <= 1'b0;
            r_div_start <= 1'b0;
            r_div_num   <= 32'd0;
            r_div_den   <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr        <= w_rr_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_zero      <= w_zero_nxt;
            r_gnt       <= w_gnt_nxt;
            r_resp_vld  <= w_resp_vld_nxt;
            r_resp_q    <= w_resp_q_nxt;
            r_resp_err  <= w_resp_err_nxt;
            r_div_start <= w_start_nxt;
            r_div_num   <= w_num_nxt;
            r_div_den   <= w_den_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign resp_vld  = r_resp_vld;
    assign resp_q    = r_resp_q;
    assign resp_err  = r_resp_err;
    assign div_start = r_div_start;
    assign div_num   = r_div_num;
    assign div_den   = r_div_den;
    assign busy      = r_busy;

endmodule

// File: tb/tb_div_sched.sv
// Testbench for div_sched (NUM_REQ=2, MAX_CYC=64). A scoreboard queue holds the
// grants and responses predicted by a cycle-level reference model; a monitor
// pops and compares whenever the DUT shows a grant or a response. The model
// follows DIV_ZERO_BYPASS_EN the same way the design build does.
module tb_div_sched;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [63:0]   req_num;
    logic [63:0]   req_den;
    logic [N-1:0]  gnt;
    logic [N-1:0]  resp_vld;
    logic [31:0]   resp_q;
    logic          resp_err;
    logic          div_start;
    logic [31:0]   div_num;
    logic [31:0]   div_den;
    logic [31:0]   div_q;
    logic          div_vld;
    logic          busy;

    div_sched #(.NUM_REQ(N), .MAX_CYC(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .req(req), .req_num(req_num), .req_den(req_den),
        .gnt(gnt), .resp_vld(resp_vld), .resp_q(resp_q), .resp_err(resp_err),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_q(div_q), .div_vld(div_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { int cyc; int idx; bit start; logic [31:0] num; logic [31:0] den; } gnt_t;
    typedef struct { int cyc; int idx; logic [31:0] q; bit err; } resp_t;
    gnt_t  exp_g[$];
    resp_t exp_r[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        failures++;
        $display("FAIL %s cycle=%0d", name, cyc);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Divider model: answers after div_lat cycles, hangs on a zero divisor or lat<0,
    // and may throw stray valids where the scheduler must ignore them.
    int          div_lat  = -1;
    int          stray_at = -100;
    bit          dv_pend  = 1'b0;
    int          dv_at    = 0;
    logic [31:0] dv_qv    = 32'd0;
    initial begin
        div_vld = 1'b0;
        div_q   = 32'd0;
        forever begin
            @(negedge clk);
            div_vld = 1'b0;
            if (rst) dv_pend = 1'b0;
            if (dv_pend && cyc == dv_at) begin
                div_vld = 1'b1;
                div_q   = dv_qv;
                dv_pend = 1'b0;
            end else if (cyc == stray_at) begin
                div_vld = 1'b1;
                div_q   = $urandom;
            end
            if (div_start && !rst) begin
                dv_pend = (div_lat > 0) && (div_den != 32'd0);
                dv_at   = cyc + div_lat;
                dv_qv   = (div_den != 32'd0) ? (div_num / div_den) : 32'd0;
                if (!div_vld && $urandom_range(0, 1) == 1) begin
                    div_vld = 1'b1;
                    div_q   = $urandom;
                end
            end
        end
    end

    // Monitor: compare every grant/response against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_g.size() > 0 && exp_g[0].cyc < cyc) begin
                fail_evt("missing_gnt");
                void'(exp_g.pop_front());
            end
            while (exp_r.size() > 0 && exp_r[0].cyc < cyc) begin
                fail_evt("missing_resp");
                void'(exp_r.pop_front());
            end
            if (gnt != '0) begin
                if (exp_g.size() == 0) begin
                    fail_evt("unexpected_gnt");
                end else begin
                    gnt_t e;
                    logic [N-1:0] oh;
                    e  = exp_g.pop_front();
                    oh = 2'b01 << e.idx;
                    chk("gnt_vec", 64'(gnt), 64'(oh));
                    chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
                    chk("div_start", 64'(div_start), 64'(e.start));
                    if (e.start) begin
                        chk("div_num", 64'(div_num), 64'(e.num));
                        chk("div_den", 64'(div_den), 64'(e.den));
                    end
                end
            end else if (div_start) begin
                fail_evt("div_start_without_gnt");
            end
            if (resp_vld != '0) begin
                if (exp_r.size() == 0) begin
                    fail_evt("unexpected_resp");
                end else begin
                    resp_t e;
                    logic [N-1:0] oh;
                    e  = exp_r.pop_front();
                    oh = 2'b01 << e.idx;
                    chk("resp_vec", 64'(resp_vld), 64'(oh));
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_q", 64'(resp_q), 64'(e.q));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                end
            end
        end
    end

    // Reference model: round-robin pointer and winner choice.
    int m_rr = 0;
    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return 0;
    endfunction

    // One operation: called on the falling edge of a cycle in which the DUT is idle.
    task automatic do_op(input logic [N-1:0] mask, input logic [31:0] n0, input logic [31:0] d0,
                         input logic [31:0] n1, input logic [31:0] d1, input int lat, input bit hold);
        logic [31:0]  nn [2];
        logic [31:0]  dd [2];
        gnt_t         g;
        resp_t        r;
        int           w;
        int           gc;
        bit           byp;
        logic [N-1:0] gl;
        nn[0] = n0; nn[1] = n1; dd[0] = d0; dd[1] = d1;
        req_num = {n1, n0};
        req_den = {d1, d0};
        req     = mask;
        w    = pick(mask);
        m_rr = (w + 1) % N;
        gc   = cyc + 1;
        byp  = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        byp  = (dd[w] == 32'd0);
`endif
        g.cyc = gc; g.idx = w; g.num = nn[w]; g.den = dd[w]; g.start = !byp;
        r.idx = w;
        if (byp) begin
            r.cyc = gc + 1; r.q = 32'hFFFF_FFFF; r.err = 1'b1;
        end else if (lat < 0 || dd[w] == 32'd0) begin
            r.cyc = gc + 64; r.q = 32'hFFFF_FFFF; r.err = 1'b1;
        end else begin
            r.cyc = gc + lat + 1; r.q = nn[w] / dd[w]; r.err = 1'b0;
        end
        div_lat = lat;
        if ($urandom_range(0, 2) == 0) stray_at = r.cyc;
        exp_g.push_back(g);
        exp_r.push_back(r);
        wait_cyc(gc);
        chk("busy_in_op", 64'(busy), 64'd1);
        req = hold ? mask : 2'b00;
        if (r.cyc > gc + 3) begin
            wait_cyc(gc + 1);
            gl  = 2'($urandom) & ~req;
            req = req | gl;
            wait_cyc(gc + 2);
            req = req & ~gl;
        end
        wait_cyc(r.cyc + 1);
        chk("busy_idle_after", 64'(busy), 64'd0);
    endtask

    // Reset while the divider hangs, then a stale valid that must be ignored.
    task automatic reset_mid_op();
        gnt_t g;
        int   gc;
        req_num = {32'd8, 32'd100};
        req_den = {32'd2, 32'd5};
        req     = 2'b01;
        g.idx   = pick(2'b01);
        m_rr    = (g.idx + 1) % N;
        gc      = cyc + 1;
        g.cyc = gc; g.start = 1'b1; g.num = 32'd100; g.den = 32'd5;
        div_lat = -1;
        exp_g.push_back(g);
        wait_cyc(gc);
        req = 2'b00;
        wait_cyc(gc + 10);
        rst  = 1'b1;
        m_rr = 0;
        wait_cyc(gc + 12);
        chk("rst_mid_ctrl", 64'({gnt, resp_vld, resp_err, div_start, busy}), 64'd0);
        chk("rst_mid_q", 64'(resp_q), 64'd0);
        chk("rst_mid_num", 64'(div_num), 64'd0);
        chk("rst_mid_den", 64'(div_den), 64'd0);
        rst      = 1'b0;
        stray_at = cyc + 1;
        wait_cyc(cyc + 4);
        chk("busy_after_stale_vld", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rden();
        if ($urandom_range(0, 7) == 0) return 32'd0;
        if ($urandom_range(0, 1) == 1) return $urandom;
        return 32'($urandom_range(1, 1000));
    endfunction

    function automatic int rlat();
        int s;
        s = $urandom_range(0, 9);
        if (s == 0) return -1;
        if (s == 1) return 63;
        return $urandom_range(1, 40);
    endfunction

    initial begin
        rst     = 1'b1;
        req     = 2'b00;
        req_num = 64'd0;
        req_den = 64'd0;
        wait_cyc(3);
        chk("rst_ctrl", 64'({gnt, resp_vld, resp_err, div_start, busy}), 64'd0);
        chk("rst_q", 64'(resp_q), 64'd0);
        chk("rst_num_den", {div_num, div_den}, 64'd0);
        rst = 1'b0;
        wait_cyc(5);
        // Both requesters held: grants must alternate 0,1,0,1 with quotients 3,4.
        for (int i = 0; i < 4; i++) do_op(2'b11, 32'd9, 32'd3, 32'd8, 32'd2, $urandom_range(2, 20), 1'b1);
        // Single operation 90/4 with a 34-cycle divider.
        do_op(2'b01, 32'd90, 32'd4, 32'd0, 32'd1, 34, 1'b0);
        // Watchdog: hung divider, valid exactly on the limit edge, one cycle before.
        do_op(2'b01, 32'd77, 32'd7, 32'd1, 32'd1, -1, 1'b0);
        do_op(2'b01, 32'd1000, 32'd7, 32'd1, 32'd1, 63, 1'b0);
        do_op(2'b10, 32'd1, 32'd1, 32'd500, 32'd9, 62, 1'b0);
        // Zero divisor on requester 1.
        do_op(2'b10, 32'd0, 32'd1, 32'd5, 32'd0, 10, 1'b0);
        // Grant requester 0 so the pointer moves, then reset mid-operation.
        do_op(2'b01, 32'd6, 32'd3, 32'd0, 32'd1, 5, 1'b0);
        reset_mid_op();
        do_op(2'b11, 32'd40, 32'd8, 32'd30, 32'd3, 5, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            do_op(2'($urandom_range(1, 3)), $urandom, rden(), $urandom, rden(), rlat(),
                  1'($urandom_range(0, 1)));
        end
        wait_cyc(cyc + 5);
        chk("scoreboard_drained", 64'(exp_g.size() + exp_r.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout cycle=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
